// File: rtl/calc_pkg.sv
// Shared types and codes for the calculator keypad controller.
package calc_pkg;

  // Controller states; the encoding is free, the names are what matter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER_A,
    ST_ENTER_B,
    ST_START,
    ST_WAIT,
    ST_SHOW,
    ST_ERROR
  } state_t;

  // Key class codes delivered by the keypad scanner.
  localparam logic [2:0] KEY_DIGIT  = 3'b000;
  localparam logic [2:0] KEY_MUL    = 3'b001;
  localparam logic [2:0] KEY_CLEAR  = 3'b010;
  localparam logic [2:0] KEY_EQUALS = 3'b111;

  // Display source selection codes.
  localparam logic [1:0] DISP_A      = 2'b00;
  localparam logic [1:0] DISP_B      = 2'b01;
  localparam logic [1:0] DISP_RESULT = 2'b10;
  localparam logic [1:0] DISP_ERROR  = 2'b11;

  // Display source shown while the controller sits in a given state.
  function automatic logic [1:0] disp_for_state(input state_t s);
    logic [1:0] d;
    case (s)
      ST_ENTER_B, ST_START, ST_WAIT: d = DISP_B;
      ST_SHOW:                       d = DISP_RESULT;
      ST_ERROR:                      d = DISP_ERROR;
      default:                       d = DISP_A;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_controller_key_edge_detect.sv
// Turns the debounced keypad level into a single-cycle key event.
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_event
);

  logic r_prev;

  // Previous key level; resets high so a key held through reset is not an event.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst) r_prev <= 1'b1;
    else      r_prev <= i_key;
  end

  assign o_event = i_key & ~r_prev;

endmodule

// File: rtl/calc_controller.sv
// Keypad-driven control FSM for a two-operand multiply calculator.
// Sequences operand entry, launches the multiplier, waits for completion
// with a timeout, and drives registered datapath strobes and display select.
module calc_controller
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 3,
  parameter int MUL_TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [2:0] key_class,
  input  logic       mul_done,
  output logic       enable_A,
  output logic       enable_B,
  output logic       load_digit,
  output logic       clear_entry,
  output logic       mul_start,
  output logic       valid,
  output logic       error,
  output logic [1:0] disp_sel,
  output logic [1:0] digit_count
);

  localparam int         CW        = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MUL_TIMEOUT - 1);
  localparam logic [1:0] MAX_CNT   = 2'(MAX_DIGITS);

  logic w_key_event;
  logic w_ev_digit, w_ev_mul, w_ev_clear, w_ev_equals;

  state_t        r_state, w_next_state;
  logic [1:0]    r_digit_count, w_next_count;
  logic [CW-1:0] r_wait_cnt, w_next_wait;
  logic          r_pending, w_next_pending;
  logic          w_next_load, w_next_clear;

  logic          r_enable_a, r_enable_b, r_load, r_clear, r_start;
  logic          r_valid, r_error;
  logic [1:0]    r_disp;

  key_edge_detect u_key_edge (
    .clk     (clk),
    .rst     (rst),
    .i_key   (key_pressed),
    .o_event (w_key_event)
  );

  assign w_ev_digit  = w_key_event && (key_class == KEY_DIGIT);
  assign w_ev_mul    = w_key_event && (key_class == KEY_MUL);
  assign w_ev_clear  = w_key_event && (key_class == KEY_CLEAR);
  assign w_ev_equals = w_key_event && (key_class == KEY_EQUALS);

  // Next-state, counters and strobe decisions for the current cycle.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    w_next_state   = r_state;
    w_next_count   = r_digit_count;
    w_next_wait    = '0;
    w_next_pending = 1'b0;
    w_next_load    = 1'b0;
    w_next_clear   = 1'b0;

    if (w_ev_clear) begin
      // Clear wins over everything, including a coincident mul_done.
      w_next_state = ST_IDLE;
      w_next_count = 2'd0;
      w_next_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ev_digit) begin
            w_next_state = ST_ENTER_A;
            w_next_load  = 1'b1;
            w_next_count = 2'd1;
          end
        end

        ST_ENTER_A: begin
          if (r_pending) begin
            // Deferred load of the digit that left SHOW.
            w_next_load = 1'b1;
          end else if (w_ev_digit && (r_digit_count < MAX_CNT)) begin
            w_next_load  = 1'b1;
            w_next_count = r_digit_count + 2'd1;
          end else if (w_ev_mul && (r_digit_count != 2'd0)) begin
            w_next_state = ST_ENTER_B;
            w_next_clear = 1'b1;
            w_next_count = 2'd0;
          end
        end

        ST_ENTER_B: begin
          if (w_ev_digit && (r_digit_count < MAX_CNT)) begin
            w_next_load  = 1'b1;
            w_next_count = r_digit_count + 2'd1;
          end else if (w_ev_equals && (r_digit_count != 2'd0)) begin
            w_next_state = ST_START;
          end
        end

        ST_START: begin
          w_next_state = ST_WAIT;
        end

        ST_WAIT: begin
          if (mul_done) begin
            w_next_state = ST_SHOW;
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_next_state = ST_ERROR;
          end else begin
            w_next_wait = r_wait_cnt + CW'(1);
          end
        end

        ST_SHOW: begin
          if (w_ev_digit) begin
            // Datapath entry is zeroed now; the digit is loaded next cycle.
            w_next_state   = ST_ENTER_A;
            w_next_clear   = 1'b1;
            w_next_pending = 1'b1;
            w_next_count   = 2'd1;
          end
        end

        ST_ERROR: begin
          w_next_state = ST_ERROR;
        end

        default: begin
          w_next_state = ST_IDLE;
          w_next_count = 2'd0;
        end
      endcase
    end
  end

  // State, counters and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_digit_count <= 2'd0;
      r_wait_cnt    <= '0;
      r_pending     <= 1'b0;
      r_enable_a    <= 1'b0;
      r_enable_b    <= 1'b0;
      r_load        <= 1'b0;
      r_clear       <= 1'b0;
      r_start       <= 1'b0;
      r_valid       <= 1'b0;
      r_error       <= 1'b0;
      r_disp        <= DISP_A;
    end else begin
      r_state       <= w_next_state;
      r_digit_count <= w_next_count;
      r_wait_cnt    <= w_next_wait;
      r_pending     <= w_next_pending;
      r_enable_a    <= (w_next_state == ST_ENTER_A);
      r_enable_b    <= (w_next_state == ST_ENTER_B);
      r_load        <= w_next_load;
      r_clear       <= w_next_clear;
      r_start       <= (w_next_state == ST_START);
      r_valid       <= (w_next_state == ST_SHOW);
      r_error       <= (w_next_state == ST_ERROR);
      r_disp        <= disp_for_state(w_next_state);
    end
  end

  assign enable_A    = r_enable_a;
  assign enable_B    = r_enable_b;
  assign load_digit  = r_load;
  assign clear_entry = r_clear;
  assign mul_start   = r_start;
  assign valid       = r_valid;
  assign error       = r_error;
  assign disp_sel    = r_disp;
  assign digit_count = r_digit_count;

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameter MAX_DIGITS, default 3: maximum decimal digits accepted per operand.
REQ-002 Parameter MUL_TIMEOUT, default 32: maximum cycles to wait for mul_done.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 key_pressed  input  1  debounced keypad level; each rising edge is one key event.
REQ-006 key_class  input  3  000 digit, 001 multiply, 010 clear, 111 equals; other codes ignored.
REQ-007 mul_done  input  1  Booth multiplier completion, one-cycle pulse.
REQ-008 enable_A  output  1  operand-A entry active.
REQ-009 enable_B  output  1  operand-B entry active.
REQ-010 load_digit  output  1  one-cycle pulse: datapath accumulates key_value into the current operand.
REQ-011 clear_entry  output  1  one-cycle pulse: datapath zeroes the temporary entry value.
REQ-012 mul_start  output  1  one-cycle pulse launching the multiplier.
REQ-013 valid  output  1  result available, level.
REQ-014 error  output  1  multiplier timeout, level.
REQ-015 disp_sel  output  2  00 A entry, 01 B entry, 10 result, 11 error.
REQ-016 digit_count  output  2  digits accepted for the current operand.

Function
REQ-017 Key event = key_pressed high while its registered previous value is low; key_class sampled on the same edge.
REQ-018 All outputs registered; the response to an event appears in the cycle after the sampling edge.
REQ-019 States: IDLE, ENTER_A, ENTER_B, START, WAIT, SHOW, ERROR.
REQ-020 IDLE: digit -> ENTER_A, load_digit, digit_count=1; clear -> clear_entry pulse, stay; other events ignored.
REQ-021 ENTER_A/ENTER_B: digit with digit_count<MAX_DIGITS -> load_digit, digit_count+1; digit at MAX_DIGITS -> ignored, no pulse.
REQ-022 ENTER_A: multiply with digit_count>0 -> ENTER_B, clear_entry, digit_count=0; multiply with digit_count=0 and equals -> ignored.
REQ-023 ENTER_B: equals with digit_count>0 -> START; equals with digit_count=0 and multiply -> ignored.
REQ-024 Clear in any state except IDLE -> IDLE, clear_entry, digit_count=0, valid=0, error=0.
REQ-025 START: mul_start high exactly one cycle, then WAIT unconditionally; key events ignored.
REQ-026 WAIT: wait counter starts at 0 on entry, increments each cycle; mul_done -> SHOW; counter reaching MUL_TIMEOUT-1 without mul_done -> ERROR; non-clear events ignored.
REQ-027 Simultaneous mul_done and timeout -> SHOW; simultaneous clear and mul_done -> IDLE.
REQ-028 SHOW: valid=1; digit -> clear_entry this cycle, ENTER_A, load_digit the following cycle (pending flag), digit_count=1; multiply/equals ignored.
REQ-029 ERROR: error=1; only clear exits.
REQ-030 enable_A=1 only in ENTER_A; enable_B=1 only in ENTER_B; at most one of load_digit, clear_entry, mul_start high per cycle.
REQ-031 disp_sel: IDLE/ENTER_A 00, ENTER_B/START/WAIT 01, SHOW 10, ERROR 11.
REQ-032 mul_done outside WAIT ignored.

Reset
REQ-033 rst low at a posedge -> IDLE, all outputs 0, digit_count 0, wait counter 0, pending flag 0.
REQ-034 Previous key_pressed register resets to 1 so a key held through reset release yields no event.
REQ-035 Reset mid-WAIT abandons the operation; a later mul_done is ignored.

Structure
REQ-036 Shared package calc_pkg holds the state enum, key_class code constants and disp_sel codes.
REQ-037 One sub-module key_edge_detect (registered previous value, event pulse out); remainder single FSM.
REQ-038 Wait counter width $clog2(MUL_TIMEOUT).

Verification
REQ-039 Keys 1,2,*,3,= with mul_done 5 cycles after mul_start -> three load_digit, one clear_entry, one mul_start, valid=1, disp_sel=10.
REQ-040 Digits 1,2,3,4 in ENTER_A -> three load_digit only, digit_count=3.
REQ-041 A entered, no mul_done for 32 cycles after mul_start -> error=1, disp_sel=11; clear -> IDLE, all outputs 0.
REQ-042 In SHOW press 7 -> clear_entry cycle N, load_digit cycle N+1, enable_A=1, valid=0.
REQ-043 Key held high across reset release -> no load_digit; * or = in IDLE -> no pulses.
REQ-044 Clear and mul_done same cycle in WAIT -> IDLE, valid stays 0.
